// File: rtl/case_1_sdiv_12s_3s_12_seq_pkg.sv
// Shared types and default widths for the case_1 sequential signed divider.
// Imported by the divider top and its handshake interface.
package case_1_sdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIN0_WIDTH_DEF = 12;
  localparam int DIN1_WIDTH_DEF = 3;
  localparam int DOUT_WIDTH_DEF = 12;
  localparam int CNT_W          = $clog2(DIN0_WIDTH_DEF);

  // Iteration counter width for an arbitrary dividend width (never below 1 bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/case_1_sdiv_12s_3s_12_seq_if.sv
// Block-level ap_start/ap_done handshake plus operand/result bus of the divider.
// master drives requests, slave is the divider.
interface case_1_sdiv_12s_3s_12_seq_if
  import case_1_sdiv_pkg::*;
#(
  parameter int din0_WIDTH = DIN0_WIDTH_DEF,
  parameter int din1_WIDTH = DIN1_WIDTH_DEF,
  parameter int dout_WIDTH = DOUT_WIDTH_DEF
) ();

  logic                         ap_start;
  logic signed [din0_WIDTH-1:0] din0;
  logic signed [din1_WIDTH-1:0] din1;
  logic                         ap_idle;
  logic                         ap_ready;
  logic                         ap_done;
  logic signed [dout_WIDTH-1:0] quot;
  logic signed [dout_WIDTH-1:0] rem;
  logic                         div_by_zero;

  modport master (
    output ap_start, din0, din1,
    input  ap_idle, ap_ready, ap_done, quot, rem, div_by_zero
  );

  modport slave (
    input  ap_start, din0, din1,
    output ap_idle, ap_ready, ap_done, quot, rem, div_by_zero
  );

endinterface

// File: rtl/case_1_sdiv_12s_3s_12_seq_udiv_step.sv
// One combinational radix-2 restoring step on unsigned magnitudes:
// shift in the next dividend bit, trial-subtract the divisor, restore on borrow.
module case_1_udiv_step #(
  parameter int REM_W = 4
) (
  input  logic [REM_W-1:0] rem_i,
  input  logic             bit_i,
  input  logic [REM_W-1:0] dvs_i,
  output logic [REM_W-1:0] rem_o,
  output logic             qbit_o
);

  logic [REM_W:0]   shifted;
  logic [REM_W+1:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = {1'b0, shifted} - {2'b00, dvs_i};
    qbit_o  = ~diff[REM_W+1];
    // Both branches are below the divisor magnitude, so REM_W bits always suffice.
    rem_o   = qbit_o ? REM_W'(diff) : REM_W'(shifted);
  end

endmodule

// File: rtl/case_1_sdiv_12s_3s_12_seq.sv
// Sequential signed divider (12s / 3s -> 12-bit quotient and remainder), truncating
// toward zero, one restoring step per cycle behind an ap_start/ap_done handshake.
module case_1_sdiv_12s_3s_12_seq
  import case_1_sdiv_pkg::*;
#(
  parameter int din0_WIDTH = DIN0_WIDTH_DEF,
  parameter int din1_WIDTH = DIN1_WIDTH_DEF,
  parameter int dout_WIDTH = DOUT_WIDTH_DEF
) (
  input logic                        ap_clk,
  input logic                        ap_rst_n,
  case_1_sdiv_12s_3s_12_seq_if.slave bus
);

  localparam int M0_W = din0_WIDTH + 1;
  localparam int M1_W = din1_WIDTH + 1;
  localparam int CW   = cnt_width(din0_WIDTH);

  function automatic logic [M0_W-1:0] mag_dvd(input logic signed [din0_WIDTH-1:0] x);
    logic [M0_W-1:0] e;
    e = {x[din0_WIDTH-1], x};
    return x[din0_WIDTH-1] ? (~e + 1'b1) : e;
  endfunction

  function automatic logic [M1_W-1:0] mag_dvs(input logic signed [din1_WIDTH-1:0] x);
    logic [M1_W-1:0] e;
    e = {x[din1_WIDTH-1], x};
    return x[din1_WIDTH-1] ? (~e + 1'b1) : e;
  endfunction

  // Conditional negate then two's-complement wrap into the output width.
  function automatic logic signed [dout_WIDTH-1:0] apply_sign(input logic [M0_W-1:0] m,
                                                             input logic            neg);
    logic [M0_W-1:0] v;
    v = neg ? (~m + 1'b1) : m;
    return dout_WIDTH'(v);
  endfunction

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic signed [dout_WIDTH-1:0] quot_q, quot_d;
  logic signed [dout_WIDTH-1:0] rem_q, rem_d;
  logic                         dzo_q, dzo_d;

  logic [M0_W-1:0]              dvd_q, dvd_d;
  logic [M1_W-1:0]              dvs_q, dvs_d;
  logic [M1_W-1:0]              prem_q, prem_d;
  logic [din0_WIDTH-1:0]        quo_q, quo_d;
  logic                         negq_q, negq_d;
  logic                         negr_q, negr_d;
  logic                         dz_q, dz_d;
  logic signed [din0_WIDTH-1:0] din0_q, din0_d;

  logic [M1_W-1:0]              step_rem;
  logic                         step_q;

  case_1_udiv_step #(
    .REM_W (M1_W)
  ) u_step (
    .rem_i  (prem_q),
    .bit_i  (dvd_q[din0_WIDTH-1]),
    .dvs_i  (dvs_q),
    .rem_o  (step_rem),
    .qbit_o (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dzo_d   = dzo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    din0_d  = din0_q;

    unique case (state_q)
      IDLE: begin
        if (bus.ap_start) begin
          din0_d  = bus.din0;
          dvd_d   = mag_dvd(bus.din0);
          dvs_d   = mag_dvs(bus.din1);
          prem_d  = '0;
          quo_d   = '0;
          negq_d  = bus.din0[din0_WIDTH-1] ^ bus.din1[din1_WIDTH-1];
          negr_d  = bus.din0[din0_WIDTH-1];
          dz_d    = (bus.din1 == '0);
          cnt_d   = CW'(din0_WIDTH - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        dvd_d  = dvd_q << 1;
        quo_d  = (quo_q << 1) | din0_WIDTH'(step_q);
        prem_d = step_rem;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        // A zero divisor still runs the full iteration; its result is overridden here.
        if (dz_q) begin
          quot_d = '0;
          rem_d  = dout_WIDTH'(din0_q);
          dzo_d  = 1'b1;
        end else begin
          quot_d = apply_sign(M0_W'(quo_q), negq_q);
          rem_d  = apply_sign(M0_W'(prem_q), negr_q);
          dzo_d  = 1'b0;
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dzo_q   <= dzo_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_d;
    prem_q <= prem_d;
    quo_q  <= quo_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
    dz_q   <= dz_d;
    din0_q <= din0_d;
  end

  assign bus.ap_idle     = (state_q == IDLE);
  assign bus.ap_ready    = (state_q == IDLE) & bus.ap_start;
  assign bus.ap_done     = (state_q == DONE);
  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dzo_q;

endmodule

// File: tb/tb_case_1_sdiv_12s_3s_12_seq.sv
// Bench for the sequential signed divider: vector table plus random model vectors,
// scoreboard checked on ap_done, and hand-written busy/reset sequences.
module tb_case_1_sdiv_12s_3s_12_seq;

  typedef struct {
    logic signed [11:0] a;
    logic signed [2:0]  b;
    logic signed [11:0] q;
    logic signed [11:0] r;
    logic               dz;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } sb_t;

  logic ap_clk;
  logic ap_rst_n;

  case_1_sdiv_12s_3s_12_seq_if bus ();

  case_1_sdiv_12s_3s_12_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   cyc    = 0;
  vec_t pend;
  sb_t  sb[$];
  sb_t  mon_it;
  vec_t tbl[14];

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int q, input int r, input bit dz);
    vec_t v;
    v.a = 12'(a); v.b = 3'(b); v.q = 12'(q); v.r = 12'(r); v.dz = dz;
    return v;
  endfunction

  function automatic vec_t model(input logic signed [11:0] a, input logic signed [2:0] b);
    vec_t v;
    int   ai, bi;
    v.a = a; v.b = b; ai = int'(a); bi = int'(b);
    if (bi == 0) begin
      v.q = '0; v.r = a; v.dz = 1'b1;
    end else begin
      v.q = 12'(ai / bi); v.r = 12'(ai % bi); v.dz = 1'b0;
    end
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic st);
    bus.din0 = v.a; bus.din1 = v.b; bus.ap_start = st; pend = v;
  endtask

  // Scoreboard: push on acceptance, pop and compare on ap_done.
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (bus.ap_idle && bus.ap_start) begin
        mon_it.v = pend; mon_it.acc = cyc;
        sb.push_back(mon_it);
      end
      if (bus.ap_done) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_it = sb.pop_front();
          chk("quot", bus.quot, mon_it.v.q);
          chk("rem", bus.rem, mon_it.v.r);
          chk("div_by_zero", bus.div_by_zero, mon_it.v.dz);
          chk("latency", cyc - mon_it.acc, 14);
        end
      end
    end
  end

  task automatic run_op(input vec_t v);
    int n0, w;
    n0 = n_done;
    @(posedge ap_clk); #1 drive(v, 1'b1);
    @(negedge ap_clk);
    chk("ready_on_start", bus.ap_ready, 1);
    w = 0;
    while (!bus.ap_idle && w < 40) begin @(negedge ap_clk); w++; end
    @(posedge ap_clk); #1 bus.ap_start = 1'b0;
    w = 0;
    while (n_done == n0 && w < 40) begin @(negedge ap_clk); w++; end
    if (n_done == n0) begin
      chk("done_timeout", 32'd1, 32'd0);
    end else begin
      @(negedge ap_clk);
      chk("done_one_cycle", bus.ap_done, 0);
      chk("hold_quot", bus.quot, v.q);
      chk("hold_rem", bus.rem, v.r);
    end
  endtask

  task automatic busy_test();
    vec_t v1, v2;
    int   n0, c0, w;
    v1 = mk(100, 3, 33, 1, 0);
    v2 = mk(7, 2, 3, 1, 0);
    n0 = n_done;
    @(posedge ap_clk); #1 drive(v1, 1'b1);
    @(negedge ap_clk);
    chk("busy_accept_ready", bus.ap_ready, 1);
    c0 = cyc;
    @(posedge ap_clk); #1 bus.ap_start = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1 drive(v2, 1'b1);
    @(negedge ap_clk);
    chk("c3_idle", bus.ap_idle, 0);
    chk("c3_ready", bus.ap_ready, 0);
    @(posedge ap_clk); #1 bus.ap_start = 1'b0;
    repeat (10) @(posedge ap_clk);
    #1 drive(v2, 1'b1);
    @(negedge ap_clk);
    chk("c14_done", bus.ap_done, 1);
    chk("c14_ready", bus.ap_ready, 0);
    @(negedge ap_clk);
    chk("c15_ready", bus.ap_ready, 1);
    chk("c15_cycle", cyc - c0, 15);
    chk("single_done", n_done - n0, 1);
    @(posedge ap_clk); #1 bus.ap_start = 1'b0;
    w = 0;
    while (n_done == n0 + 1 && w < 40) begin @(negedge ap_clk); w++; end
    chk("second_done", n_done - n0, 2);
  endtask

  task automatic reset_abort_test();
    int n0;
    n0 = n_done;
    @(posedge ap_clk); #1 drive(mk(100, 3, 33, 1, 0), 1'b1);
    @(negedge ap_clk);
    chk("abort_accept_ready", bus.ap_ready, 1);
    @(posedge ap_clk); #1 bus.ap_start = 1'b0;
    repeat (5) @(posedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("abort_idle", bus.ap_idle, 1);
    chk("abort_quot", bus.quot, 0);
    chk("abort_rem", bus.rem, 0);
    chk("abort_done", bus.ap_done, 0);
    sb.delete();
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (20) @(negedge ap_clk);
    chk("abort_no_done", n_done, n0);
    run_op(mk(7, 2, 3, 1, 0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(100, 3, 33, 1, 0);
    tbl[1]  = mk(-100, 3, -33, -1, 0);
    tbl[2]  = mk(100, -4, -25, 0, 0);
    tbl[3]  = mk(-2048, -1, -2048, 0, 0);
    tbl[4]  = mk(2047, -4, -511, 3, 0);
    tbl[5]  = mk(5, 0, 0, 5, 1);
    tbl[6]  = mk(-7, 2, -3, -1, 0);
    tbl[7]  = mk(7, -3, -2, 1, 0);
    tbl[8]  = mk(-2048, 3, -682, -2, 0);
    tbl[9]  = mk(-1, -4, 0, -1, 0);
    tbl[10] = mk(0, -1, 0, 0, 0);
    tbl[11] = mk(-2048, 0, 0, -2048, 1);
    tbl[12] = mk(2047, 1, 2047, 0, 0);
    tbl[13] = mk(-5, -2, 2, -1, 0);

    ap_clk = 1'b0;
    ap_rst_n = 1'b1;
    bus.ap_start = 1'b0;
    bus.din0 = '0;
    bus.din1 = '0;
    #2 ap_rst_n = 1'b0;
    repeat (3) @(negedge ap_clk);
    chk("rst_idle", bus.ap_idle, 1);
    chk("rst_ready", bus.ap_ready, 0);
    chk("rst_done", bus.ap_done, 0);
    chk("rst_quot", bus.quot, 0);
    chk("rst_rem", bus.rem, 0);
    chk("rst_dz", bus.div_by_zero, 0);
    @(posedge ap_clk); #1 ap_rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_op(tbl[i]);

    busy_test();
    run_op(mk(-5, -2, 2, -1, 0));
    reset_abort_test();

    for (int i = 0; i < 20; i++) begin
      logic signed [11:0] ra;
      logic signed [2:0]  rb;
      ra = 12'($urandom);
      rb = 3'($urandom);
      run_op(model(ra, rb));
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
